video_core_config_ctrl: RTL

Sequencer that programs the bypass register of every core in the video line-buffer daisy chain from board switches over the shared Avalon-MM write port. Synchronises and debounces the push-button and switch inputs, then issues one single-cycle write per core, in core order, on a key press or (optionally) any switch change. Sits in the `sys_clk` domain between the board top and the `avs_*_core_*` slave ports, replacing the ad-hoc bypass write strobe.

---
 rtl/video_ctrl_pkg.sv | 16 +
 rtl/video_core_config_ctrl_debounce.sv | 53 +++++
 rtl/video_core_config_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/video_ctrl_pkg.sv
// Shared types and constants for the video core
// configuration sequencer.
package video_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITE,
    GAP,
    DONE
  } cfg_state_t;

  localparam logic CORE_BYPASS_ADDR = 1'b0;
  localparam int   AVS_DATA_W       = 32;

endpackage

// File: rtl/video_core_config_ctrl_debounce.sv
// Two-flop synchroniser followed by a debouncer
// with one shared stability counter per vector.
module signal_debounce #(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = 2,
  parameter logic [WIDTH-1:0] RST_VAL         = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    run;
  logic             accept;

  // Length of the current stable run; any change restarts it.
  always_comb begin
    run    = (s2 != s3) ? CW'(1) : cnt + CW'(1);
    accept = (s2 != dout) && (run >= LIM);
  end

  // Synchroniser chain and debounced value update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      s3   <= RST_VAL;
      dout <= RST_VAL;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (accept) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= run;
      end
    end
  end

endmodule

// File: rtl/video_core_config_ctrl.sv
// Writes each core's bypass bit from debounced
// switches on key press, switch change or power-up.
import video_ctrl_pkg::*;

module video_core_config_ctrl #(
  parameter int NUM_CORE        = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  key_n,
  input  logic [NUM_CORE-1:0]   sw,
  input  logic                  auto_en,
  output logic                  avs_address,
  output logic [AVS_DATA_W-1:0] avs_writedata,
  output logic [NUM_CORE-1:0]   avs_write,
  output logic                  busy,
  output logic [7:0]            update_cnt
);

  localparam int IW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CORE - 1);

  logic                key_db;
  logic                key_q;
  logic [NUM_CORE-1:0] sw_db;
  logic [NUM_CORE-1:0] sw_q;
  logic                press;
  logic                sw_chg;
  logic                trig;
  logic                pending;
  logic                pending_nx;
  logic                cap;
  cfg_state_t          state;
  cfg_state_t          state_nx;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nx;
  logic [NUM_CORE-1:0] shadow;
  logic [NUM_CORE-1:0] shadow_nx;
  logic [7:0]          cnt_nx;

  signal_debounce #(
    .WIDTH          (1),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        (1'b1)
  ) u_key_db (
    .clk (sys_clk),
    .rst (sys_rst),
    .din (key_n),
    .dout(key_db)
  );

  signal_debounce #(
    .WIDTH          (NUM_CORE),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RST_VAL        ('0)
  ) u_sw_db (
    .clk (sys_clk),
    .rst (sys_rst),
    .din (sw),
    .dout(sw_db)
  );

  assign trig = press | (sw_chg & auto_en);

  // Next-state, shadow capture and completion count.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    shadow_nx = shadow;
    cnt_nx    = update_cnt;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (pending | trig) begin
          state_nx = CAPTURE;
          cap      = 1'b1;
        end
      end
      CAPTURE: begin
        shadow_nx = sw_db;
        idx_nx    = '0;
        state_nx  = WRITE;
      end
      WRITE: state_nx = GAP;
      GAP: begin
        if (idx == LAST) begin
          state_nx = DONE;
        end else begin
          idx_nx   = idx + IW'(1);
          state_nx = WRITE;
        end
      end
      DONE: begin
        cnt_nx   = update_cnt + 8'd1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    pending_nx = (pending | trig) & ~cap;
  end

  // Edge detect, pending flag and sequencer state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_q      <= 1'b1;
      sw_q       <= '0;
      press      <= 1'b0;
      sw_chg     <= 1'b0;
      pending    <= 1'b1;
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      update_cnt <= '0;
    end else begin
      key_q      <= key_db;
      sw_q       <= sw_db;
      press      <= key_q & ~key_db;
      sw_chg     <= (sw_q != sw_db);
      pending    <= pending_nx;
      state      <= state_nx;
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      update_cnt <= cnt_nx;
    end
  end

  // Bus outputs decoded from state, idx and shadow.
  always_comb begin
    avs_address   = CORE_BYPASS_ADDR;
    avs_write     = '0;
    avs_writedata = '0;
    busy          = (state != IDLE);
    if (state == WRITE) begin
      avs_write     = NUM_CORE'(1) << idx;
      avs_writedata = AVS_DATA_W'(shadow[idx]);
    end
  end

endmodule
